multipad_io: RTL
================

MULTIPAD_IO -- requirements
Module: multipad_io

Interface
REQ-001 Parameter NPADS, default 2: number of independent pad channels, legal range 1..4.
REQ-002 Parameter TMO_CYC, default 11600: CE cycles of TH-low-free inactivity after which the 6-button sequence counter resets.
REQ-003 Parameter FLT_CYC, default 210: CE cycles after a channel enters input direction before its TH pulls up to 1.
REQ-004 CLK  in  1  system clock; single clock domain.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
REQ-007 BTN  in  NPADS*12  per channel {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}, bits 11..0 of each 12-bit slice, active-low (0 = pressed).
REQ-008 MODE6  in  NPADS  per channel 1 = 6-button pad, 0 = 3-button pad.
REQ-009 SEL  in  NPADS  per channel data-port access strobe; at most one bit high at a time.
REQ-010 RNW  in  1  1 = read, 0 = write.
REQ-011 DIR  in  NPADS  per channel TH direction: 0 = host drives TH, 1 = TH is an input to the host.
REQ-012 DI  in  1  host write value for TH (data bit 6).
REQ-013 DO  out  NPADS*8  per channel pad data byte.
REQ-014 DTACK_N  out  1  active-low access acknowledge.

Function
REQ-015 Each channel SHALL hold TH, a 2-bit sequence counter JCNT, a 17-bit saturating idle timer JTMR, an 8-bit saturating float timer FLTMR, and a latched write bit WB.
REQ-016 DIR=0 SHALL load TH<=WB and clear FLTMR; DIR=1 SHALL increment FLTMR, saturating at 255, and set TH<=1 on the CE cycle in which FLTMR equals FLT_CYC.
REQ-017 A TH rising edge, detected against a one-CE-delayed copy, SHALL increment JCNT modulo 4 (3 wraps to 0).
REQ-018 JCNT SHALL be forced to 0 when JTMR > TMO_CYC or MODE6=0; a simultaneous rising edge takes priority over this clear.
REQ-019 A TH falling edge SHALL clear JTMR; otherwise JTMR increments, saturating at all-ones.
REQ-020 DO[7]=0 and DO[6]=TH; DO[5:0] SHALL be combinational from TH and JCNT:
  - TH=1, JCNT!=3: {C,B,RIGHT,LEFT,DOWN,UP}
  - TH=1, JCNT=3: {C,B,MODE,X,Y,Z}
  - TH=0, JCNT<2: {START,A,0,0,DOWN,UP}
  - TH=0, JCNT=2: {START,A,0,0,0,0}
  - TH=0, JCNT=3: {START,A,1,1,1,1}
REQ-021 Handshake: on a CE cycle with any SEL bit high and DTACK_N=1, DTACK_N SHALL go 0; with RNW=0, the selected channel SHALL latch WB<=DI in the same cycle.
REQ-022 DTACK_N SHALL return to 1 on the first CE cycle with all SEL bits low; holding SEL high SHALL produce exactly one WB latch per access.
REQ-023 A WB change SHALL reach TH one CE cycle after the latch, and only while DIR=0.

Reset
REQ-024 RESET SHALL immediately set DTACK_N=1, TH=0, JCNT=0 and WB=0 in every channel, aborting any access in progress.
REQ-025 On reset, DO SHALL present {0,0,START,A,0,0,DOWN,UP} for each channel.
REQ-026 JTMR and FLTMR SHALL be reset to 0.

Configuration
REQ-027 Macro MULTIPAD_SNAPSHOT_EN defined: each channel SHALL copy BTN into a 12-bit snapshot on every CE cycle with JCNT=0 and hold it while JCNT!=0, and REQ-020 SHALL read the snapshot.
REQ-028 MULTIPAD_SNAPSHOT_EN undefined: REQ-020 SHALL read live BTN, and no snapshot register SHALL exist.

Structure
REQ-029 Package gen_pad_pkg SHALL hold the button index constants (UP=0 .. Z=11), the 12-bit button typedef, and the JCNT typedef.
REQ-030 Sub-module pad_chan SHALL implement one channel (REQ-015..020, 023, 027); multipad_io SHALL generate NPADS instances and own the shared DTACK_N logic.

Verification
REQ-031 DIR=0; write DI=1, 0, 1, 0, 1, 0, 1 with BTN slice 0xFFE (UP pressed), MODE6=1 -> DO[5:0] reads 0x3E, 0x32, 0x3E, 0x30, 0x3F (JCNT=3, TH=1), 0x3F, 0x3E.
REQ-032 Same sequence with MODE6=0 -> every TH=1 read gives {C,B,R,L,D,U}, and no read ever shows the 0x0F low nibble.
REQ-033 JCNT=2, then TMO_CYC+2 CE cycles with no TH edges -> JCNT=0, and the next TH=0 read shows DOWN/UP bits.
REQ-034 Set DIR=1 with TH=0 -> TH reads 0 for FLT_CYC-1 CE cycles, then 1 (DO[6]=1).
REQ-035 SEL held high for 10 CE cycles with RNW=0 -> DTACK_N=0 from the second CE cycle on, WB latched once, DTACK_N=1 one CE cycle after SEL falls; assert RESET mid-access -> DTACK_N=1 at once.
REQ-036 With MULTIPAD_SNAPSHOT_EN, change BTN while JCNT=1 -> DO is unchanged until JCNT returns to 0; NPADS=4 -> channel 3 toggling leaves channels 0..2 unaffected.

Source files
------------

// File: rtl/gen_pad_pkg.sv
// gen_pad_pkg
//   Shared definitions for the multi-pad I/O block.
//   - Button bit positions inside each 12-bit button slice (UP=0 .. Z=11).
//   - btn_t  : one pad's 12 active-low buttons {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}.
//   - jcnt_t : the 2-bit sequence counter that walks a 6-button pad through its read phases.
//   - padData: maps TH, the sequence counter and the buttons onto data bits 5..0.

package gen_pad_pkg;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_MODE  = 8;
   localparam int BTN_X     = 9;
   localparam int BTN_Y     = 10;
   localparam int BTN_Z     = 11;

   typedef logic [11:0] btn_t;
   typedef logic [1:0]  jcnt_t;

   // With TH high a pad shows the directional group, except in the fourth
   // phase of a 6-button pad where the extra buttons appear instead. With TH
   // low a pad shows START/A, and the low nibble doubles as an ID code:
   // forced to 0000 in the third phase and 1111 in the fourth.
   function automatic logic [5:0] padData(input logic th, input jcnt_t jcnt, input btn_t btn);
      logic [5:0] d;
      d = '0;
      if (th) begin
         if (jcnt == 2'd3)
            d = {btn[BTN_C], btn[BTN_B], btn[BTN_MODE], btn[BTN_X], btn[BTN_Y], btn[BTN_Z]};
         else
            d = {btn[BTN_C], btn[BTN_B], btn[BTN_RIGHT], btn[BTN_LEFT], btn[BTN_DOWN], btn[BTN_UP]};
      end else begin
         case (jcnt)
            2'd2:    d = {btn[BTN_START], btn[BTN_A], 4'b0000};
            2'd3:    d = {btn[BTN_START], btn[BTN_A], 4'b1111};
            default: d = {btn[BTN_START], btn[BTN_A], 2'b00, btn[BTN_DOWN], btn[BTN_UP]};
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/pad_chan.sv
// pad_chan
//   One pad channel: TH line, 6-button sequence counter, idle timer,
//   TH float timer and latched host write bit, plus the data byte mux.
//   Ports:
//     CLK, RESET  clock and asynchronous active-high reset
//     CE          clock enable; nothing advances without it
//     BTN         12 active-low buttons of this pad
//     MODE6       1 = 6-button pad, 0 = 3-button pad
//     DIR         0 = host drives TH, 1 = TH floats (pulls up after FLT_CYC)
//     WR_EN       host write strobe for this channel (already qualified)
//     DI          host write value for TH
//     DO          data byte {0, TH, data[5:0]}
//   Optional feature: define MULTIPAD_SNAPSHOT_EN to freeze the buttons seen
//   by the data mux while a 6-button read sequence is in progress.

module pad_chan
   import gen_pad_pkg::*;
#(
   parameter int TMO_CYC = 11600,
   parameter int FLT_CYC = 210
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CE,
   input  btn_t       BTN,
   input  logic       MODE6,
   input  logic       DIR,
   input  logic       WR_EN,
   input  logic       DI,
   output logic [7:0] DO
);

   localparam logic [16:0] TMO_LIM = 17'(TMO_CYC);
   localparam logic [7:0]  FLT_HIT = 8'(FLT_CYC);

   logic        th;
   logic        thDly;
   logic        wb;
   jcnt_t       jcnt;
   logic [16:0] jtmr;
   logic [7:0]  fltmr;
   logic [7:0]  fltNext;
   logic        thRise;
   logic        thFall;
   btn_t        btnSrc;

   // Edge detection compares TH against its copy from the previous enabled
   // cycle; the float timer's next value is computed here so the pull-up can
   // fire in the very cycle the timer reaches FLT_CYC.
   always_comb begin
      thRise  = th & ~thDly;
      thFall  = ~th & thDly;
      fltNext = (fltmr == 8'hFF) ? fltmr : fltmr + 8'd1;
   end

   // TH follows the latched write bit while the host owns the line, so a new
   // write shows up on TH one enabled cycle after it is latched. When the line
   // is released TH keeps its level until the float timer expires, then pulls
   // up and stays up.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         th    <= 1'b0;
         thDly <= 1'b0;
         wb    <= 1'b0;
         fltmr <= 8'd0;
      end else if (CE) begin
         thDly <= th;
         if (WR_EN)
            wb <= DI;
         if (!DIR) begin
            th    <= wb;
            fltmr <= 8'd0;
         end else begin
            fltmr <= fltNext;
            if (fltNext == FLT_HIT)
               th <= 1'b1;
         end
      end
   end

   // The sequence counter advances on every TH rising edge. A 3-button pad
   // or a long stretch without TH going low returns it to phase 0, but an edge
   // arriving in the same cycle still wins so a read sequence is never lost.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         jcnt <= 2'd0;
         jtmr <= 17'd0;
      end else if (CE) begin
         if (thFall)
            jtmr <= 17'd0;
         else if (jtmr != '1)
            jtmr <= jtmr + 17'd1;
         if (thRise)
            jcnt <= jcnt + 2'd1;
         else if ((jtmr > TMO_LIM) || !MODE6)
            jcnt <= 2'd0;
      end
   end

`ifdef MULTIPAD_SNAPSHOT_EN
   btn_t snap;

   // In phase 0 the snapshot tracks the live buttons every enabled cycle;
   // once a sequence starts it holds, so all phases of one read report the
   // same button state. The mux bypasses to live buttons in phase 0, which is
   // what the snapshot would contain anyway and keeps the reset view live.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         snap <= '1;
      else if (CE && (jcnt == 2'd0))
         snap <= BTN;
   end

   assign btnSrc = (jcnt == 2'd0) ? BTN : snap;
`else
   assign btnSrc = BTN;
`endif

   assign DO = {1'b0, th, padData(th, jcnt, btnSrc)};

endmodule

// File: rtl/multipad_io.sv
// multipad_io
//   NPADS independent pad channels behind one shared access handshake.
//   Ports:
//     CLK, RESET  clock and asynchronous active-high reset
//     CE          clock enable
//     BTN         NPADS x 12 active-low buttons, channel i in bits [12i+11:12i]
//     MODE6       per channel 1 = 6-button pad
//     SEL         per channel access strobe (at most one high)
//     RNW         1 = read, 0 = write
//     DIR         per channel TH direction (1 = TH floats)
//     DI          host write value for TH
//     DO          NPADS x 8 data bytes, channel i in bits [8i+7:8i]
//     DTACK_N     active-low access acknowledge
//   Optional feature: MULTIPAD_SNAPSHOT_EN (see pad_chan).

module multipad_io
   import gen_pad_pkg::*;
#(
   parameter int NPADS   = 2,
   parameter int TMO_CYC = 11600,
   parameter int FLT_CYC = 210
) (
   input  logic [NPADS*12-1:0] BTN,
   input  logic                CLK,
   input  logic                RESET,
   input  logic                CE,
   input  logic [NPADS-1:0]    MODE6,
   input  logic [NPADS-1:0]    SEL,
   input  logic                RNW,
   input  logic [NPADS-1:0]    DIR,
   input  logic                DI,
   output logic [NPADS*8-1:0]  DO,
   output logic                DTACK_N
);

   localparam int BTN_W = $bits(btn_t);

   logic             anySel;
   logic [NPADS-1:0] wrEn;

   // A write is taken only in the first enabled cycle of an access, while
   // the acknowledge is still idle; holding SEL therefore latches once.
   always_comb begin
      anySel = |SEL;
      wrEn   = SEL & {NPADS{CE & DTACK_N & ~RNW}};
   end

   // Acknowledge drops on the first enabled cycle with a strobe and stays low
   // while it is held; it releases on the first enabled cycle with no strobe.
   // Reset forces it idle immediately, abandoning any access in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         DTACK_N <= 1'b1;
      else if (CE)
         DTACK_N <= ~anySel;
   end

   // One channel per pad, each with its own slice of the button and data buses.
   for (genvar i = 0; i < NPADS; i++) begin : gChan
      pad_chan #(
         .TMO_CYC (TMO_CYC),
         .FLT_CYC (FLT_CYC)
      ) uChan (
         .CLK   (CLK),
         .RESET (RESET),
         .CE    (CE),
         .BTN   (BTN[i*BTN_W +: BTN_W]),
         .MODE6 (MODE6[i]),
         .DIR   (DIR[i]),
         .WR_EN (wrEn[i]),
         .DI    (DI),
         .DO    (DO[i*8 +: 8])
      );
   end

endmodule
